// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared sizes and entry type for the fetch-to-decode instruction queue.
//   DEPTH  queue entries (power of two, >= 4)
//   PTR_W  head/tail pointer width, log2(DEPTH)
//   INST_W instruction width, ADDR_W pc width
package inst_queue_pkg;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = PTR_W + 1;
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } iq_entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular {inst, pc} FIFO between fetch and decode, flushed on ROB redirect.
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global ready; low freezes push/pop
//   if_valid/if_inst/if_pc    fetch write port
//   iq_full                   registered back-pressure to fetch
//   flush                     ROB redirect; discards every entry
//   iss_ready                 decode accepts the head entry
//   iss_valid/iss_inst/iss_pc head entry presented to decode
module inst_queue
    import inst_queue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              iq_full,
    input  logic              flush,
    input  logic              iss_ready,
    output logic              iss_valid,
    output logic [INST_W-1:0] iss_inst,
    output logic [ADDR_W-1:0] iss_pc
);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SLACK_CNT = CNT_W'(DEPTH - 1);

    iq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             iq_full_q, iq_full_d, push, pop;

    assign iss_valid = (count_q != '0) & ~flush;
    assign iss_inst  = mem_q[head_q].inst;
    assign iss_pc    = mem_q[head_q].pc;
    assign iq_full   = iq_full_q;

    // Push acceptance uses the registered count, so a full queue refuses a push
    // even when a pop happens in the same cycle. Pointers wrap by truncation.
    always_comb begin
        push      = if_valid & rdy & ~flush & (count_q != FULL_CNT);
        pop       = iss_valid & iss_ready & rdy;
        head_d    = head_q + PTR_W'(pop);
        tail_d    = tail_q + PTR_W'(push);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        // Raise one slot early so the strobe fetch already registered still fits.
        iq_full_d = rdy ? (count_d >= SLACK_CNT) : iq_full_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            iq_full_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            iq_full_q <= iq_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{inst: if_inst, pc: if_pc};
    end
endmodule
